// File: rtl/pck_flitizer.sv
// Packet injector front end: accepts one packet descriptor at a time and emits
// header/body/tail flits onto the router local input, gated by per-VC credits.
module pck_flitizer #(
  parameter int unsigned V           = 4,
  parameter int unsigned B           = 4,
  parameter int unsigned Fpay        = 32,
  parameter int unsigned EAw         = 4,
  parameter int unsigned DAw         = 4,
  parameter int unsigned Cw          = 1,
  parameter int unsigned PCK_INJ_Dw  = 64,
  parameter int unsigned MAX_PCK_SIZ = 16,
  localparam int unsigned PCK_SIZw   = $clog2(MAX_PCK_SIZ + 1),
  localparam int unsigned CRDTw      = $clog2(B + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [EAw-1:0]        current_e_addr,
  input  logic                  pck_wr,
  input  logic [V-1:0]          pck_vc,
  input  logic [DAw-1:0]        pck_dest,
  input  logic [Cw-1:0]         pck_class,
  input  logic [PCK_SIZw-1:0]   pck_size,
  input  logic [PCK_INJ_Dw-1:0] pck_data,
  output logic [V-1:0]          pck_ready,
  output logic                  pck_sent,
  output logic                  flit_wr_out,
  output logic [2+V+Fpay-1:0]   flit_out,
  input  logic [V-1:0]          credit_in,
  output logic                  busy
);

  localparam int unsigned HDRDw = Fpay - EAw - DAw - Cw;
  localparam int unsigned CSw   = CRDTw + 1;
  localparam int unsigned SHw   = $clog2(HDRDw + MAX_PCK_SIZ * Fpay + 1);
  localparam int unsigned DXw   = PCK_INJ_Dw + Fpay;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_n;
  logic [V-1:0]              vc_q;
  logic [DAw-1:0]            dest_q;
  logic [Cw-1:0]             class_q;
  logic [EAw-1:0]            src_q;
  logic [PCK_INJ_Dw-1:0]     data_q;
  logic [PCK_SIZw-1:0]       eff_q, idx_q, eff_size;
  logic [V-1:0][CRDTw-1:0]   credit, credit_n;
  logic [V-1:0][CSw-1:0]     credit_sum;
  logic [V-1:0]              credit_nz, dec, at_max;
  logic                      accept, issue, last;
  logic [Fpay-1:0]           payload;
  logic [SHw-1:0]            body_shift;
  logic [DXw-1:0]            data_ext;

  // Zero-length requests become one flit; oversize requests are clamped.
  always_comb begin
    eff_size = pck_size;
    if (pck_size == '0)
      eff_size = PCK_SIZw'(1);
    else if (pck_size > PCK_SIZw'(MAX_PCK_SIZ))
      eff_size = PCK_SIZw'(MAX_PCK_SIZ);
  end

  always_comb begin
    for (int v = 0; v < V; v++) credit_nz[v] = (credit[v] != '0);
  end

  assign pck_ready = (state == IDLE) ? credit_nz : '0;

  // Next-state and issue control.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        accept = pck_wr && |(pck_vc & pck_ready);
        if (accept) state_n = SEND;
      end
      SEND: begin
        issue = |(vc_q & credit_nz);
        last  = (idx_q == eff_q - PCK_SIZw'(1));
        if (issue && last) state_n = IDLE;
      end
    endcase
  end

  // Header carries src/dest/class plus the low data bits; bodies continue the data stream.
  always_comb begin
    data_ext   = {{Fpay{1'b0}}, data_q};
    body_shift = SHw'(HDRDw) + SHw'(idx_q - PCK_SIZw'(1)) * SHw'(Fpay);
    if (idx_q == '0)
      payload = {data_q[HDRDw-1:0], class_q, dest_q, src_q};
    else
      payload = Fpay'(data_ext >> body_shift);
  end

  // Credit bookkeeping: returns add, issues subtract, result saturates at B.
  always_comb begin
    dec = issue ? vc_q : '0;
    for (int v = 0; v < V; v++) begin
      credit_sum[v] = CSw'(credit[v]) + CSw'(credit_in[v]) - CSw'(dec[v]);
      at_max[v]     = (credit[v] == CRDTw'(B));
      credit_n[v]   = (credit_sum[v] > CSw'(B)) ? CRDTw'(B) : CRDTw'(credit_sum[v]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) credit[v] <= CRDTw'(B);
      vc_q        <= '0;
      dest_q      <= '0;
      class_q     <= '0;
      src_q       <= '0;
      data_q      <= '0;
      eff_q       <= '0;
      idx_q       <= '0;
      flit_wr_out <= 1'b0;
      flit_out    <= '0;
      pck_sent    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      credit      <= credit_n;
      busy        <= (state_n == SEND);
      flit_wr_out <= issue;
      pck_sent    <= issue && last;
      flit_out    <= issue ? {(idx_q == '0), last, vc_q, payload} : '0;
      if (accept) begin
        vc_q    <= pck_vc;
        dest_q  <= pck_dest;
        class_q <= pck_class;
        src_q   <= current_e_addr;
        data_q  <= pck_data;
        eff_q   <= eff_size;
        idx_q   <= '0;
      end else if (issue) begin
        idx_q   <= idx_q + PCK_SIZw'(1);
      end
    end
  end

  vc_onehot: assert property (@(posedge clk) disable iff (!reset)
    (pck_wr && state == IDLE) |-> $onehot(pck_vc));

  credit_overflow: assert property (@(posedge clk) disable iff (!reset)
    (credit_in & ~dec & at_max) == '0);

endmodule

// File: tb/tb_pck_flitizer.sv
// Directed bench for pck_flitizer: hand-computed flits, credit stall/return,
// size clamping, busy rejection and mid-packet reset.
module tb_pck_flitizer;

  logic        clk;
  logic        reset;
  logic [3:0]  current_e_addr;
  logic        pck_wr;
  logic [3:0]  pck_vc;
  logic [3:0]  pck_dest;
  logic [0:0]  pck_class;
  logic [4:0]  pck_size;
  logic [63:0] pck_data;
  logic [3:0]  pck_ready;
  logic        pck_sent;
  logic        flit_wr_out;
  logic [37:0] flit_out;
  logic [3:0]  credit_in;
  logic        busy;

  int          n_vec, n_err, n_flits, n_sent;
  logic [37:0] last_flit;

  pck_flitizer dut (
    .clk(clk), .reset(reset), .current_e_addr(current_e_addr),
    .pck_wr(pck_wr), .pck_vc(pck_vc), .pck_dest(pck_dest),
    .pck_class(pck_class), .pck_size(pck_size), .pck_data(pck_data),
    .pck_ready(pck_ready), .pck_sent(pck_sent), .flit_wr_out(flit_wr_out),
    .flit_out(flit_out), .credit_in(credit_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      tick();
      if (flit_wr_out) begin
        n_flits++;
        last_flit = flit_out;
      end
      if (pck_sent) n_sent++;
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    pck_wr    = 1'b0;
    credit_in = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic request(input logic [3:0] vc, input logic [3:0] dest, input logic cls,
                         input logic [4:0] size, input logic [63:0] data);
    pck_vc    = vc;
    pck_dest  = dest;
    pck_class = cls;
    pck_size  = size;
    pck_data  = data;
    pck_wr    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; n_flits = 0; n_sent = 0; last_flit = '0;
    current_e_addr = 4'd3;
    pck_vc = '0; pck_dest = '0; pck_class = '0; pck_size = '0; pck_data = '0;
    pck_wr = 1'b0; credit_in = '0; reset = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_flit_wr", 64'(flit_wr_out), 64'd0);
    check_eq("rst_flit_out", 64'(flit_out), 64'd0);
    check_eq("rst_sent", 64'(pck_sent), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(pck_ready), 64'hF);
    reset = 1'b1;

    // Single-flit packet
    request(4'b0010, 4'd5, 1'b1, 5'd1, 64'h7);
    tick();
    pck_wr = 1'b0;
    check_eq("single_busy_T1", 64'(busy), 64'd1);
    check_eq("single_nowr_T1", 64'(flit_wr_out), 64'd0);
    check_eq("single_ready_T1", 64'(pck_ready), 64'h0);
    tick();
    check_eq("single_wr_T2", 64'(flit_wr_out), 64'd1);
    check_eq("single_flit", 64'(flit_out), 64'h32_0000_0F53);
    check_eq("single_sent", 64'(pck_sent), 64'd1);
    check_eq("single_credit1", 64'(dut.credit[1]), 64'd3);
    tick();
    check_eq("single_idle_wr", 64'(flit_wr_out), 64'd0);
    check_eq("single_idle_ready", 64'(pck_ready), 64'hF);

    // Data slicing across four flits
    apply_reset();
    request(4'b0001, 4'd9, 1'b0, 5'd4, 64'hFEDCBA9876543210);
    tick();
    pck_wr = 1'b0;
    tick();
    check_eq("slice_hdr", 64'(flit_out), 64'h21_A864_2093);
    tick();
    check_eq("slice_body1", 64'(flit_out), 64'h01_B975_30EC);
    check_eq("slice_body1_sent", 64'(pck_sent), 64'd0);
    tick();
    check_eq("slice_body2", 64'(flit_out), 64'h01_0000_01FD);
    tick();
    check_eq("slice_tail", 64'(flit_out), 64'h11_0000_0000);
    check_eq("slice_tail_sent", 64'(pck_sent), 64'd1);
    check_eq("slice_ready", 64'(pck_ready), 64'hE);
    check_eq("slice_credit0", 64'(dut.credit[0]), 64'd0);

    // Simultaneous issue and credit return
    apply_reset();
    request(4'b0001, 4'd1, 1'b0, 5'd4, 64'h0);
    tick();
    pck_wr    = 1'b0;
    credit_in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) credit_in = '0;
      check_eq($sformatf("ret_wr%0d", i), 64'(flit_wr_out), 64'd1);
      check_eq($sformatf("ret_credit%0d", i), 64'(dut.credit[0]), 64'd4);
    end
    check_eq("ret_tail_sent", 64'(pck_sent), 64'd1);

    // Credit stall and resume
    apply_reset();
    request(4'b0001, 4'd2, 1'b0, 5'd6, 64'h1234);
    tick();
    pck_wr = 1'b0;
    n_flits = 0; n_sent = 0;
    run_cycles(8);
    check_eq("stall_flits", 64'(n_flits), 64'd4);
    check_eq("stall_nosent", 64'(n_sent), 64'd0);
    check_eq("stall_ready0", 64'(pck_ready[0]), 64'd0);
    check_eq("stall_busy", 64'(busy), 64'd1);
    credit_in = 4'b0001;
    run_cycles(2);
    credit_in = '0;
    run_cycles(4);
    check_eq("resume_flits", 64'(n_flits), 64'd6);
    check_eq("resume_sent", 64'(n_sent), 64'd1);
    check_eq("resume_tail_flags", 64'(last_flit[37:36]), 64'h1);
    check_eq("resume_credit0", 64'(dut.credit[0]), 64'd0);

    // Requests during SEND are ignored
    apply_reset();
    request(4'b0001, 4'd2, 1'b0, 5'd4, 64'h0);
    tick();
    n_flits = 0; n_sent = 0;
    request(4'b0010, 4'd7, 1'b1, 5'd1, 64'h55);
    run_cycles(2);
    pck_wr = 1'b0;
    run_cycles(8);
    check_eq("busy_rej_flits", 64'(n_flits), 64'd4);
    check_eq("busy_rej_sent", 64'(n_sent), 64'd1);
    check_eq("busy_rej_vc", 64'(last_flit[35:32]), 64'h1);
    check_eq("busy_rej_credit1", 64'(dut.credit[1]), 64'd4);

    // Zero size becomes a single header+tail flit
    apply_reset();
    request(4'b0100, 4'd3, 1'b0, 5'd0, 64'h1);
    tick();
    pck_wr = 1'b0;
    n_flits = 0; n_sent = 0;
    run_cycles(5);
    check_eq("size0_flits", 64'(n_flits), 64'd1);
    check_eq("size0_sent", 64'(n_sent), 64'd1);
    check_eq("size0_flags", 64'(last_flit[37:36]), 64'h3);
    check_eq("size0_vc", 64'(last_flit[35:32]), 64'h4);

    // Oversize request is clamped to 16 flits
    apply_reset();
    request(4'b0001, 4'd4, 1'b1, 5'd20, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    pck_wr    = 1'b0;
    credit_in = 4'b0001;
    n_flits = 0; n_sent = 0;
    run_cycles(16);
    credit_in = '0;
    run_cycles(4);
    check_eq("clamp_flits", 64'(n_flits), 64'd16);
    check_eq("clamp_sent", 64'(n_sent), 64'd1);
    check_eq("clamp_tail_flags", 64'(last_flit[37:36]), 64'h1);
    check_eq("clamp_credit0", 64'(dut.credit[0]), 64'd4);

    // Reset mid-packet, then a fresh packet
    apply_reset();
    request(4'b0001, 4'd6, 1'b0, 5'd6, 64'hABCD);
    tick();
    pck_wr = 1'b0;
    n_flits = 0; n_sent = 0;
    run_cycles(2);
    check_eq("midrst_pre_flits", 64'(n_flits), 64'd2);
    reset = 1'b0;
    #1;
    check_eq("midrst_wr", 64'(flit_wr_out), 64'd0);
    check_eq("midrst_flit", 64'(flit_out), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_sent", 64'(pck_sent), 64'd0);
    check_eq("midrst_ready", 64'(pck_ready), 64'hF);
    check_eq("midrst_credit0", 64'(dut.credit[0]), 64'd4);
    tick();
    tick();
    reset = 1'b1;
    request(4'b1000, 4'd2, 1'b0, 5'd1, 64'h1);
    tick();
    pck_wr = 1'b0;
    tick();
    check_eq("post_rst_wr", 64'(flit_wr_out), 64'd1);
    check_eq("post_rst_flit", 64'(flit_out), 64'h38_0000_0223);
    check_eq("post_rst_sent", 64'(pck_sent), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
